// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and types used by the fetch stage.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0]      OPC_BRANCH   = 7'b1100011;
    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            pred_taken;
    } if_id_t;

    typedef enum logic [0:0] {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Sequential/predicted next-PC selection for the fetch stage.
// With STATIC_BP_EN defined, backward conditional branches are predicted taken (BTFN).
module pc_next_sel
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] next_pc,
    output logic            pred_taken
);

`ifdef STATIC_BP_EN
    logic [XLEN-1:0] b_imm;
    logic            is_back_branch;

    // A negative B-immediate (instr[31] set) means a backward branch, assumed to be a loop.
    always_comb begin
        b_imm          = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        is_back_branch = (instr[6:0] == OPC_BRANCH) && instr[31];
        next_pc        = pc + 32'd4;
        pred_taken     = 1'b0;
        if (is_back_branch) begin
            next_pc    = pc + b_imm;
            pred_taken = 1'b1;
        end
    end
`else
    logic unused_instr;

    assign unused_instr = ^instr;
    assign next_pc      = pc + 32'd4;
    assign pred_taken   = 1'b0;
`endif

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, redirect/stall handling and ebreak halt.
// Optional macro STATIC_BP_EN enables backward-taken static branch prediction in pc_next_sel.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = riscv_pkg::EBREAK_INSTR,
    parameter logic [31:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_out,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_pred_taken,
    output logic        halted
);

    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR, pred_taken: 1'b0};

    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] seq_next_pc;
    logic            pred_taken;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    pc_next_sel u_pc_next_sel (
        .pc         (pc_q),
        .instr      (imem_rdata),
        .next_pc    (seq_next_pc),
        .pred_taken (pred_taken)
    );

    // Priority: redirect > stall > halted > normal fetch; reset is applied in the register process.
    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            if_id_d = IF_ID_BUBBLE;
            state_d = FETCH_RUN;
        end else if (!stall) begin
            if (state_q == FETCH_HALTED) begin
                if_id_d = IF_ID_BUBBLE;
            end else begin
                if_id_d = '{valid: 1'b1, pc: pc_q, instr: imem_rdata, pred_taken: pred_taken};
                if (imem_rdata == HALT_INSTR) begin
                    state_d = FETCH_HALTED;
                end else begin
                    pc_d = seq_next_pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            if_id_q <= IF_ID_BUBBLE;
            state_q <= FETCH_RUN;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            state_q <= state_d;
        end
    end

    assign imem_addr     = pc_q;
    assign pc_out        = pc_q;
    assign id_valid      = if_id_q.valid;
    assign id_pc         = if_id_q.pc;
    assign id_instr      = if_id_q.instr;
    assign id_pred_taken = if_id_q.pred_taken;
    assign halted        = (state_q == FETCH_HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed per-edge vectors push expectations, a monitor pops and compares.
// Expectations for the branch vector follow STATIC_BP_EN when it is defined.
module tb_if_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] id_pc;
        logic [31:0] instr;
        logic        pred;
        logic        halted;
    } exp_t;

`ifdef STATIC_BP_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] pc_out;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_pred_taken;
    logic        halted;

    logic halt_en = 1'b0;
    logic br_en   = 1'b0;

    int n_compared = 0;
    int n_failed   = 0;

    exp_t  exp_q[$];
    string name_q[$];

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_out         (pc_out),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_pred_taken  (id_pred_taken),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory model: imem[a] = a | 0x13, with optional halt at 0xC and backward beq at 0x10.
    always_comb begin
        imem_rdata = imem_addr | 32'h0000_0013;
        if (halt_en && imem_addr == 32'h0000_000C) imem_rdata = 32'h0010_0073;
        if (br_en && imem_addr == 32'h0000_0010) imem_rdata = 32'hFE00_0CE3;
    end

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_failed++;
            $display("[TB] FAIL %s.%s: got %h expected %h", name, field, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                                 input string name,
                                 input logic [31:0] e_pc, input logic e_v, input logic [31:0] e_idpc,
                                 input logic [31:0] e_instr, input logic e_pred, input logic e_halt);
        exp_t e;
        @(negedge clk);
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        e = '{pc: e_pc, valid: e_v, id_pc: e_idpc, instr: e_instr, pred: e_pred, halted: e_halt};
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: one expectation is consumed per active edge, sampled 1ns after it.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checkOutput(nm, "pc_out", pc_out, e.pc);
                checkOutput(nm, "imem_addr", imem_addr, e.pc);
                checkOutput(nm, "id_valid", {31'b0, id_valid}, {31'b0, e.valid});
                checkOutput(nm, "id_pc", id_pc, e.id_pc);
                checkOutput(nm, "id_instr", id_instr, e.instr);
                checkOutput(nm, "id_pred_taken", {31'b0, id_pred_taken}, {31'b0, e.pred});
                checkOutput(nm, "halted", {31'b0, halted}, {31'b0, e.halted});
            end
        end
    end

    initial begin
        int waited;
        // Reset state
        applyStimulus(1, 0, 0, 32'h0, "rst0", 32'h0, 0, 32'h0, 32'h13, 0, 0);
        applyStimulus(1, 0, 0, 32'h0, "rst1", 32'h0, 0, 32'h0, 32'h13, 0, 0);
        // Free run
        applyStimulus(0, 0, 0, 32'h0, "run0", 32'h4, 1, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, "run1", 32'h8, 1, 32'h4, 32'h17, 0, 0);
        // Stall holds PC and IF/ID
        applyStimulus(0, 1, 0, 32'h0, "stall0", 32'h8, 1, 32'h4, 32'h17, 0, 0);
        applyStimulus(0, 1, 0, 32'h0, "stall1", 32'h8, 1, 32'h4, 32'h17, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, "release", 32'hC, 1, 32'h8, 32'h1B, 0, 0);
        // Redirect beats stall, low bits cleared
        applyStimulus(0, 1, 1, 32'h43, "redir_stall", 32'h40, 0, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, "after_redir", 32'h44, 1, 32'h40, 32'h53, 0, 0);
        // Halt at 0xC
        halt_en = 1'b1;
        applyStimulus(0, 0, 1, 32'hC, "redir_c", 32'hC, 0, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, "halt_fetch", 32'hC, 1, 32'hC, 32'h0010_0073, 0, 1);
        applyStimulus(0, 0, 0, 32'h0, "halted0", 32'hC, 0, 32'h0, 32'h13, 0, 1);
        applyStimulus(0, 0, 0, 32'h0, "halted1", 32'hC, 0, 32'h0, 32'h13, 0, 1);
        applyStimulus(0, 0, 1, 32'h20, "redir_20", 32'h20, 0, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, "after_20", 32'h24, 1, 32'h20, 32'h33, 0, 0);
        // Backward branch at 0x10 (beq x0,x0,-8)
        br_en = 1'b1;
        applyStimulus(0, 0, 1, 32'h10, "redir_10", 32'h10, 0, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 1, 0, 32'h0, "stall_br", 32'h10, 0, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, "branch", BP ? 32'h8 : 32'h14, 1, 32'h10, 32'hFE00_0CE3, BP, 0);
        applyStimulus(0, 0, 0, 32'h0, "after_branch", BP ? 32'hC : 32'h18, 1,
                      BP ? 32'h8 : 32'h14, BP ? 32'h1B : 32'h17, 0, 0);
        // PC wrap-around
        applyStimulus(0, 0, 1, 32'hFFFF_FFFF, "redir_wrap", 32'hFFFF_FFFC, 0, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, "wrap", 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0, 0);
        // Reset while halted and stalled (and redirecting)
        applyStimulus(0, 0, 1, 32'hC, "redir_c2", 32'hC, 0, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, "halt2", 32'hC, 1, 32'hC, 32'h0010_0073, 0, 1);
        applyStimulus(0, 1, 0, 32'h0, "halt_stall", 32'hC, 1, 32'hC, 32'h0010_0073, 0, 1);
        applyStimulus(1, 1, 1, 32'h80, "mid_rst", 32'h0, 0, 32'h0, 32'h13, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, "resume", 32'h4, 1, 32'h0, 32'h13, 0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_failed++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
